// File: rtl/dds_pkg.sv
// Shared defaults and the quarter-wave sine table for the DDS sine generator.
package dds_pkg;

  localparam int DEF_PHASE_W = 24;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LUT_AW  = 6;
  localparam int LUT_DW      = 7;
  localparam int LUT_DEPTH   = 64;

  // Entry k is round(127*sin(2*pi*(k+0.5)/256)). The half-step offset keeps
  // the table symmetric under mirroring, so no quadrant ever addresses zero
  // and the output never reaches -128.
  localparam logic [LUT_DW-1:0] QLUT [LUT_DEPTH] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

endpackage

// File: rtl/sine_qlut.sv
// Registered quarter-wave sine ROM: unsigned magnitude one cycle after address.
module sine_qlut
  import dds_pkg::*;
#(
  parameter int LUT_AW = DEF_LUT_AW
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [LUT_DW-1:0] data
);

  // Synchronous table read; contents are constant so no reset is needed.
  always_ff @(posedge clk) begin
    data <= QLUT[addr];
  end

endmodule

// File: rtl/dds_sine.sv
// Direct digital synthesis sine source: phase accumulator with a
// phase-continuous retune handshake, followed by a 3-stage quarter-wave
// lookup (mirror address, ROM read, sign apply).
module dds_sine
  import dds_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LUT_AW  = DEF_LUT_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       fcw,
  input  logic                     fcw_valid,
  output logic                     fcw_ready,
  output logic signed [DATA_W-1:0] sample,
  output logic                     sample_valid,
  output logic                     phase_wrap
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] fcw_active;
  logic [PHASE_W-1:0] fcw_pend;
  logic               pend_full;
  logic [PHASE_W:0]   phase_sum;
  logic               carry;
  logic               accept;
  logic               apply;

  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;

  logic [LUT_AW-1:0]  addr_p0;
  logic               neg_p0;
  logic               vld_p0;
  logic [LUT_DW-1:0]  mag_p1;
  logic               neg_p1;
  logic               vld_p1;

  // Scale the unsigned table magnitude to the output width and negate for
  // the lower half-wave; magnitudes top out at 127 so negation cannot wrap.
  function automatic logic signed [DATA_W-1:0] apply_sign(
    input logic [LUT_DW-1:0] mag,
    input logic              neg
  );
    logic signed [DATA_W-1:0] m;
    m = signed'(DATA_W'(mag));
    return neg ? -m : m;
  endfunction

  assign phase_sum = {1'b0, phase} + {1'b0, fcw_active};
  assign carry     = phase_sum[PHASE_W];
  assign fcw_ready = !pend_full;
  assign accept    = fcw_valid && fcw_ready;
  // Idle accumulator retunes immediately; a running one waits for the wrap
  // so the new step starts from a phase near zero with no discontinuity.
  assign apply     = pend_full && (!en || carry);

  assign quad = phase[PHASE_W-1 -: 2];
  assign idx  = phase[PHASE_W-3 -: LUT_AW];

  // Phase accumulator and its registered carry-out pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      phase_wrap <= 1'b0;
    end else begin
      if (en) phase <= phase_sum[PHASE_W-1:0];
      phase_wrap <= en && carry;
    end
  end

  // Active step and pending-slot occupancy; accept and apply are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw_active <= '0;
      pend_full  <= 1'b0;
    end else begin
      if (apply) begin
        fcw_active <= fcw_pend;
        pend_full  <= 1'b0;
      end
      if (accept) pend_full <= 1'b1;
    end
  end

  // Pending step value; only meaningful while pend_full is set.
  always_ff @(posedge clk) begin
    if (accept) fcw_pend <= fcw;
  end

  // Stage p0: quadrant decode, odd quadrants read the table mirrored.
  always_ff @(posedge clk) begin
    addr_p0 <= quad[0] ? ~idx : idx;
    neg_p0  <= quad[1];
  end

  // Stage p1: registered ROM read, sign travels alongside.
  sine_qlut #(
    .LUT_AW (LUT_AW)
  ) u_qlut (
    .clk  (clk),
    .addr (addr_p0),
    .data (mag_p1)
  );

  // Sign flag delayed to line up with the ROM output.
  always_ff @(posedge clk) begin
    neg_p1 <= neg_p0;
  end

  // Valid pipeline tracking en through all three stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      vld_p0       <= en;
      vld_p1       <= vld_p0;
      sample_valid <= vld_p1;
    end
  end

  // Stage p2: sign apply; output holds while no valid sample arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample <= '0;
    end else if (vld_p1) begin
      sample <= apply_sign(mag_p1, neg_p1);
    end
  end

endmodule

// File: tb/tb_dds_sine.sv
// Directed bench for dds_sine with a reference phase model and sample scoreboard.
module tb_dds_sine;

  localparam int    PHASE_W = 24;
  localparam int    DATA_W  = 8;
  localparam real   PI      = 3.14159265358979323846;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic [PHASE_W-1:0]       fcw;
  logic                     fcw_valid;
  logic                     fcw_ready;
  logic signed [DATA_W-1:0] sample;
  logic                     sample_valid;
  logic                     phase_wrap;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t sb[$];

  logic [PHASE_W-1:0] m_phase;
  logic [PHASE_W-1:0] m_active;
  logic [PHASE_W-1:0] m_pend_fcw;
  logic               m_pend;
  logic               m_wrap;
  logic               m_acc;
  logic signed [31:0] last;

  dds_sine dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fcw          (fcw),
    .fcw_valid    (fcw_valid),
    .fcw_ready    (fcw_ready),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase_wrap   (phase_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lut_ref(int k);
    real x;
    x = 127.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 256.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int ref_sample(logic [PHASE_W-1:0] p);
    int top, quad, i, m;
    top  = int'(p[PHASE_W-1 -: 8]);
    quad = top / 64;
    i    = top % 64;
    m    = (quad == 0 || quad == 2) ? lut_ref(i) : lut_ref(63 - i);
    return (quad >= 2) ? -m : m;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = '0;
    m_active   = '0;
    m_pend_fcw = '0;
    m_pend     = 1'b0;
    m_wrap     = 1'b0;
    m_acc      = 1'b0;
    last       = 0;
    sb.delete();
  endtask

  // One clock: model the edge, check control outputs after it, then check
  // the sample port at the following falling edge.
  task automatic cycle();
    logic [PHASE_W:0]   s;
    logic [PHASE_W-1:0] f;
    logic               acc, app, e;
    exp_t               x;
    s   = {1'b0, m_phase} + {1'b0, m_active};
    f   = fcw;
    e   = en;
    acc = fcw_valid && !m_pend;
    app = m_pend && (!e || s[PHASE_W]);
    if (e) sb.push_back('{val: ref_sample(m_phase), due: cyc + 3});
    @(posedge clk);
    #1;
    if (e) m_phase = s[PHASE_W-1:0];
    m_wrap = e && s[PHASE_W];
    if (app) begin
      m_active = m_pend_fcw;
      m_pend   = 1'b0;
    end
    if (acc) begin
      m_pend_fcw = f;
      m_pend     = 1'b1;
    end
    m_acc = acc;
    chk("phase_wrap", phase_wrap, m_wrap);
    chk("fcw_ready", fcw_ready, !m_pend);
    @(negedge clk);
    if (sample_valid === 1'b1) begin
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("sample", sample, x.val);
        chk("latency", cyc, x.due);
      end
      last = sample;
    end else begin
      chk("sample_hold", sample, last);
    end
  endtask

  initial begin
    logic [PHASE_W:0] t;
    rst       = 1'b1;
    en        = 1'b0;
    fcw       = '0;
    fcw_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample", sample, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_fcw_ready", fcw_ready, 1);
    chk("rst_phase_wrap", phase_wrap, 0);
    @(negedge clk);
    rst = 1'b0;

    // Load unit step while idle, then run one full cycle plus a few samples
    fcw       = 24'h010000;
    fcw_valid = 1'b1;
    cycle();
    fcw_valid = 1'b0;
    cycle();
    en = 1'b1;
    repeat (260) cycle();

    // Retune at phase 0x100000 to step 2; a second offer waits while pending
    for (int n = 0; n < 300 && m_phase != 24'h100000; n++) cycle();
    fcw       = 24'h020000;
    fcw_valid = 1'b1;
    cycle();
    fcw = 24'h030000;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (m_acc) break;
    end
    fcw_valid = 1'b0;
    repeat (20) cycle();

    // Enable dropped for 5 cycles mid-run
    en = 1'b0;
    repeat (5) cycle();
    en = 1'b1;
    repeat (20) cycle();

    // Offer accepted on the very cycle of a carry applies at the next carry
    for (int n = 0; n < 400 && m_pend; n++) cycle();
    for (int n = 0; n < 400; n++) begin
      t = {1'b0, m_phase} + {1'b0, m_active};
      if (t[PHASE_W]) break;
      cycle();
    end
    fcw       = 24'h800000;
    fcw_valid = 1'b1;
    cycle();
    fcw_valid = 1'b0;
    for (int n = 0; n < 400 && m_pend; n++) cycle();
    repeat (10) cycle();

    // Zero step freezes phase while samples keep flowing
    en        = 1'b0;
    fcw       = '0;
    fcw_valid = 1'b1;
    cycle();
    fcw_valid = 1'b0;
    cycle();
    en = 1'b1;
    repeat (10) cycle();

    // Leave a step pending, then reset asynchronously between edges
    fcw       = 24'h123456;
    fcw_valid = 1'b1;
    cycle();
    fcw_valid = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sample", sample, 0);
    chk("async_rst_sample_valid", sample_valid, 0);
    chk("async_rst_fcw_ready", fcw_ready, 1);
    chk("async_rst_phase_wrap", phase_wrap, 0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_sample", sample, 0);
    @(negedge clk);
    rst = 1'b0;

    // Half-rate tone from a clean start: 2, -2, ... with a wrap every 2 cycles
    fcw       = 24'h800000;
    fcw_valid = 1'b1;
    cycle();
    fcw_valid = 1'b0;
    cycle();
    en = 1'b1;
    repeat (12) cycle();

    // Drain the pipeline
    en = 1'b0;
    repeat (5) cycle();
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sine.md
DDS_SINE -- requirements
Module: dds_sine

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-002 SHALL have parameter DATA_W, default 8, signed sample width.
REQ-003 SHALL have parameter LUT_AW, default 6, quarter-wave table address width (64 entries).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  accumulate enable.
REQ-007 SHALL have port fcw  input  PHASE_W  frequency control word (phase step per enabled cycle).
REQ-008 SHALL have port fcw_valid  input  1  fcw offered.
REQ-009 SHALL have port fcw_ready  output  1  fcw can be accepted; transfer when fcw_valid && fcw_ready.
REQ-010 SHALL have port sample  output  DATA_W  signed sine sample; feeds the PWM comparator data input.
REQ-011 SHALL have port sample_valid  output  1  sample updated this cycle.
REQ-012 SHALL have port phase_wrap  output  1  one-cycle pulse, registered accumulator carry-out.

Function
REQ-013 Accumulator SHALL add the active fcw modulo 2^PHASE_W on every cycle with en=1 and SHALL hold when en=0.
REQ-014 Accepted fcw SHALL go to a one-entry pending register; fcw_ready SHALL be 0 while pending is full.
REQ-015 With en=0, pending SHALL become active on the next cycle; with en=1, on the cycle after the addition that carries out (phase-continuous retune).
REQ-016 Acceptance in the same cycle as a carry SHALL apply at the next carry, not this one.
REQ-017 fcw=0 SHALL freeze phase while en=1; sample_valid still pulses each cycle.
REQ-018 Table index: quadrant q = phase[PHASE_W-1:PHASE_W-2], i = next LUT_AW bits; q0 lut[i], q1 lut[63-i], q2 -lut[i], q3 -lut[63-i].
REQ-019 lut[k] SHALL equal round(127*sin(2*pi*(k+0.5)/256)); lut[0]=2, lut[1]=5, lut[63]=127; sample range -127..127, -128 never produced.
REQ-020 Pipeline SHALL be 3 stages (address/mirror, ROM read, sign apply); sample of phase P appears exactly 3 cycles after the edge on which P is registered.
REQ-021 sample_valid SHALL follow en through the same 3-cycle delay; sample SHALL hold its last value when sample_valid=0.
REQ-022 phase_wrap SHALL be aligned with the accumulator, not the sample pipeline.

Reset
REQ-023 On rst: phase=0, active fcw=0, pending empty, fcw_ready=1, sample=0, sample_valid=0, phase_wrap=0, all pipeline valids 0, asynchronously.
REQ-024 rst mid-operation SHALL discard pending fcw and in-flight samples; first sample_valid after release needs a new fcw and 3 enabled cycles.
REQ-025 ROM output register SHALL need no reset.

Structure
REQ-026 Package dds_pkg SHALL hold PHASE_W, DATA_W, LUT_AW defaults and the quarter-wave table constant.
REQ-027 Sub-module sine_qlut SHALL implement the registered 64x7-bit unsigned quarter-wave ROM.

Verification
REQ-028 Reset, load fcw=0x010000 with en=0, then en=1 -> first sample_valid 3 cycles later; samples 2,5,... ; phase 64 -> 127, 128 -> -2, 192 -> -127; phase_wrap every 256 cycles.
REQ-029 fcw=0x800000 -> samples alternate 2,-2; phase_wrap every 2 cycles.
REQ-030 Running 0x010000, offer 0x020000 at phase 0x100000 -> accepted, fcw_ready=0, step stays 1 until carry, then step 2, no phase jump.
REQ-031 Second fcw_valid while pending -> fcw_ready=0, not accepted; accepted the cycle after pending applies.
REQ-032 en low 5 cycles mid-run -> phase held, sample_valid low 5 cycles after 3-cycle lag, sample held, resume continues from held phase.
REQ-033 rst asserted between clock edges mid-run -> sample=0, sample_valid=0, fcw_ready=1 before next edge.
